// File: rtl/bird_draw.sv
// bird_draw: erases the sprite at its previous position, then draws a solid
// BOX_W x BOX_H box at a new position. One pixel is written per cycle, in
// raster order (x inner, y outer), through the vga_adapter pixel interface.
//
// Optional feature: define BIRD_DRAW_ERASE_EN to erase the previous box
// before each draw. Without it, every start goes directly to DRAW and no
// old-position register exists.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : draw request, sampled only while idle
//   x_in      : [7:0] new top-left x
//   y_in      : [6:0] new top-left y
//   colour_in : [2:0] sprite colour
//   x_out     : [7:0] pixel x
//   y_out     : [6:0] pixel y
//   colour    : [2:0] pixel colour
//   plot      : pixel write strobe (0 for pixels off the 160x120 screen)
//   busy      : high whenever an operation is in progress
//   done      : one-cycle completion pulse
module bird_draw #(
   parameter int         BOX_W     = 4,
   parameter int         BOX_H     = 4,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   input  logic [2:0] colour_in,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef BIRD_DRAW_ERASE_EN
   localparam logic [1:0] S_ERASE = 2'd1;
`endif
   localparam logic [1:0] S_DRAW  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] LAST_X = 4'(BOX_W - 1);
   localparam logic [3:0] LAST_Y = 4'(BOX_H - 1);

   logic [1:0] state;
   // Counters hold the offset of the pixel currently on the outputs.
   logic [3:0] cnt_x, cnt_y;
   logic [7:0] lat_x;
   logic [6:0] lat_y;
   logic [2:0] lat_c;
`ifdef BIRD_DRAW_ERASE_EN
   logic [7:0] old_x;
   logic [6:0] old_y;
   logic       old_valid;
`endif

   logic       last_x, last_px;
   logic [3:0] nxt_x, nxt_y;
   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [3:0] off_x, off_y;
   logic [2:0] pix_c;
   logic [8:0] px;
   logic [7:0] py;
   logic       pix_on;

   // Work out the pixel to present after the coming edge. Outputs are
   // registered, so the next pixel is computed one cycle ahead of display.
   always_comb begin
      last_x  = (cnt_x == LAST_X);
      last_px = last_x && (cnt_y == LAST_Y);
      nxt_x   = last_x ? 4'd0 : 4'(cnt_x + 4'd1);
      nxt_y   = last_x ? 4'(cnt_y + 4'd1) : cnt_y;
      base_x  = lat_x;
      base_y  = lat_y;
      off_x   = nxt_x;
      off_y   = nxt_y;
      pix_c   = lat_c;
      case (state)
         S_IDLE: begin
            // First pixel of a new operation comes straight from the inputs.
            base_x = x_in;
            base_y = y_in;
            off_x  = 4'd0;
            off_y  = 4'd0;
            pix_c  = colour_in;
`ifdef BIRD_DRAW_ERASE_EN
            if (old_valid) begin
               base_x = old_x;
               base_y = old_y;
               pix_c  = BG_COLOUR;
            end
`endif
         end
`ifdef BIRD_DRAW_ERASE_EN
         S_ERASE: begin
            if (last_px) begin
               // Hand over to the first draw pixel at the latched position.
               off_x = 4'd0;
               off_y = 4'd0;
            end else begin
               base_x = old_x;
               base_y = old_y;
               pix_c  = BG_COLOUR;
            end
         end
`endif
         default: ;
      endcase
      // Widened sums so pixels past the screen edge clip instead of wrapping.
      px     = {1'b0, base_x} + {5'd0, off_x};
      py     = {1'b0, base_y} + {4'd0, off_y};
      pix_on = (px <= 9'd159) && (py <= 8'd119);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt_x     <= '0;
         cnt_y     <= '0;
         lat_x     <= '0;
         lat_y     <= '0;
         lat_c     <= '0;
         x_out     <= '0;
         y_out     <= '0;
         colour    <= '0;
         plot      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef BIRD_DRAW_ERASE_EN
         old_x     <= '0;
         old_y     <= '0;
         old_valid <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               plot <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  lat_x  <= x_in;
                  lat_y  <= y_in;
                  lat_c  <= colour_in;
                  cnt_x  <= '0;
                  cnt_y  <= '0;
                  x_out  <= px[7:0];
                  y_out  <= py[6:0];
                  colour <= pix_c;
                  plot   <= pix_on;
                  busy   <= 1'b1;
`ifdef BIRD_DRAW_ERASE_EN
                  state  <= old_valid ? S_ERASE : S_DRAW;
`else
                  state  <= S_DRAW;
`endif
               end
            end
`ifdef BIRD_DRAW_ERASE_EN
            S_ERASE: begin
               x_out  <= px[7:0];
               y_out  <= py[6:0];
               colour <= pix_c;
               plot   <= pix_on;
               if (last_px) begin
                  cnt_x <= '0;
                  cnt_y <= '0;
                  state <= S_DRAW;
               end else begin
                  cnt_x <= nxt_x;
                  cnt_y <= nxt_y;
               end
            end
`endif
            S_DRAW: begin
               if (last_px) begin
                  plot   <= 1'b0;
                  done   <= 1'b1;
                  colour <= BG_COLOUR;
                  state  <= S_DONE;
               end else begin
                  cnt_x  <= nxt_x;
                  cnt_y  <= nxt_y;
                  x_out  <= px[7:0];
                  y_out  <= py[6:0];
                  colour <= pix_c;
                  plot   <= pix_on;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               cnt_x <= '0;
               cnt_y <= '0;
               state <= S_IDLE;
`ifdef BIRD_DRAW_ERASE_EN
               old_x     <= lat_x;
               old_y     <= lat_y;
               old_valid <= 1'b1;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
